// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the front end: opcodes, fetch buffer entry,
// immediate decoders and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions; clear wins over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, talks to instruction memory, predicts
// JAL and backward branches taken, and buffers words for Decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         o_imem_req,
  output logic [31:0]  o_imem_addr,
  input  logic         i_imem_ack,
  input  logic [31:0]  i_imem_data,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic [31:0]  i_branch_pc,
  output logic [31:0]  o_instr,
  output logic [31:0]  o_pc,
  output logic         o_valid,
  output logic         o_prediction,
  output fetch_state_e dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, pc_nxt, squash_addr, squash_addr_nxt;
  logic [31:0]   next_pc;
  logic          pred, push, pop, empty;
  logic [CW-1:0] count;
  fetch_entry_t  wr_entry, head;

  always_comb begin
    pred    = 1'b0;
    next_pc = pc + 32'd4;
    if (i_imem_data[6:0] == OPC_JAL) begin
      pred    = 1'b1;
      next_pc = pc + imm_j(i_imem_data);
    end else if (i_imem_data[6:0] == OPC_BRANCH && i_imem_data[31]) begin
      pred    = 1'b1;
      next_pc = pc + imm_b(i_imem_data);
    end
  end

  // Memory handshake: o_imem_req is a valid, i_imem_ack the matching ready/response.
  // Once req rises, req and addr hold until ack; an ack in the req cycle completes it,
  // and an ack while req is low is ignored. Only one request is ever outstanding.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    squash_addr_nxt = squash_addr;
    o_imem_req      = 1'b0;
    push            = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
        if (i_flush) pc_nxt = i_branch_pc;
      end
      ST_FETCH: begin
        o_imem_req = (count < DEPTH_CNT);
        if (i_flush) begin
          pc_nxt = i_branch_pc;
          // A request already on the bus must still complete at its old address.
          if (o_imem_req && !i_imem_ack) begin
            state_nxt       = ST_SQUASH;
            squash_addr_nxt = pc;
          end
        end else if (o_imem_req && i_imem_ack) begin
          push   = 1'b1;
          pc_nxt = next_pc;
        end
      end
      ST_SQUASH: begin
        o_imem_req = 1'b1;
        if (i_flush)    pc_nxt    = i_branch_pc;
        if (i_imem_ack) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      squash_addr <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      squash_addr <= squash_addr_nxt;
    end
  end

  assign o_imem_addr = (state == ST_SQUASH) ? squash_addr : pc;
  assign wr_entry    = '{pc: pc, instr: i_imem_data, pred: pred};
  assign pop         = o_valid && !i_stall && !i_flush;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .clear   (i_flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );

  assign o_valid      = !empty;
  assign o_instr      = empty ? NOP_INSTR : head.instr;
  assign o_pc         = empty ? 32'h0 : head.pc;
  assign o_prediction = !empty && head.pred;
  assign dbg_state    = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder with programmable latency,
// expected-output and expected-request queues checked by negedge monitors.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BNE  = 32'h0043_1663;
  localparam logic [31:0] BEQ  = 32'hFE00_0EE3;
  localparam logic [31:0] JAL  = 32'h0080_006F;
  localparam logic [31:0] JALR = 32'h0082_8467;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         o_imem_req;
  logic [31:0]  o_imem_addr;
  logic         i_imem_ack;
  logic [31:0]  i_imem_data;
  logic         i_stall;
  logic         i_flush;
  logic [31:0]  i_branch_pc;
  logic [31:0]  o_instr;
  logic [31:0]  o_pc;
  logic         o_valid;
  logic         o_prediction;
  fetch_state_e dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 0;
  bit ph2 = 1'b0;
  int wait_cnt;

  logic [64:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [64:0] exp_e;
  logic [31:0] exp_a;
  logic        pend;
  logic [31:0] pend_addr;

  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_data  (i_imem_data),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_branch_pc  (i_branch_pc),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_valid      (o_valid),
    .o_prediction (o_prediction),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit p2);
    if (a == 32'h08) return BNE;
    if (p2) begin
      case (a)
        32'h10:  return BEQ;
        32'h14:  return JAL;
        32'h1C:  return JALR;
        default: ;
      endcase
    end
    return NOP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wait_cnt <= 0;
    else if (o_imem_req && !i_imem_ack) wait_cnt <= wait_cnt + 1;
    else                               wait_cnt <= 0;
  end

  always_comb begin
    i_imem_ack  = o_imem_req && (wait_cnt >= lat);
    i_imem_data = i_imem_ack ? mem_word(o_imem_addr, ph2) : 32'h0;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic ent(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    exp_q.push_back({pc, instr, pred});
  endtask

  task automatic ads(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && !i_stall && !i_flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fifo_out: unexpected pc %h instr %h, expected nothing", o_pc, o_instr);
      end else begin
        exp_e = exp_q.pop_front();
        chk("fifo_out", {o_pc, o_instr, o_prediction}, exp_e);
      end
    end
    if (rst_n && o_imem_req && i_imem_ack) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL imem_addr: unexpected request %h, expected nothing", o_imem_addr);
      end else begin
        exp_a = exp_addr_q.pop_front();
        chk("imem_addr", o_imem_addr, exp_a);
      end
    end
    if (!rst_n) pend = 1'b0;
    else begin
      if (pend) chk("req_hold", {o_imem_req, o_imem_addr}, {1'b1, pend_addr});
      pend      = o_imem_req && !i_imem_ack;
      pend_addr = o_imem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_req",   o_imem_req, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc",    o_pc, 32'h0);
    chk("rst_pred",  o_prediction, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
  endtask

  // Release reset, check the first request, run k cycles unstalled, then stall.
  task automatic reset_run(input int k);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    chk("first_req",   o_imem_req, 1'b1);
    chk("first_addr",  o_imem_addr, 32'h0);
    chk("first_valid", o_valid, 1'b0);
    chk("first_state", dbg_state, ST_FETCH);
    @(posedge clk); #1;
    if (k > 1) tick(k - 1);
    i_stall = 1'b1;
  endtask

  task automatic release_run(input int n);
    i_stall = 1'b0;
    tick(n);
    i_stall = 1'b1;
    tick(2);
  endtask

  // Flush from a full, stalled buffer: refills two entries, stays stalled.
  task automatic flush_quiet(input logic [31:0] target);
    i_flush     = 1'b1;
    i_branch_pc = target;
    tick(1);
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_pc",    o_pc, 32'h0);
    chk("flush_instr", o_instr, NOP);
    @(posedge clk); #1;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_branch_pc = 32'h0;
    tick(2);
    @(negedge clk);
    check_reset();

    // Sequential fetch, bne at 0x08 not taken
    for (int a = 0; a <= 32'h20; a += 4) ads(a);
    for (int a = 0; a <= 32'h18; a += 4) ent(a, (a == 8) ? BNE : NOP, 1'b0);
    reset_run(8);

    // Stall: buffer full, request drops, head holds
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_pc",    o_pc, 32'h1C);
      chk("stall_instr", o_instr, NOP);
      chk("stall_valid", o_valid, 1'b1);
      if (i > 0) chk("stall_req", o_imem_req, 1'b0);
      @(posedge clk); #1;
    end
    ads(32'h24); ads(32'h28); ads(32'h2C); ads(32'h30);
    ent(32'h1C, NOP, 1'b0); ent(32'h20, NOP, 1'b0); ent(32'h24, NOP, 1'b0); ent(32'h28, NOP, 1'b0);
    release_run(4);

    // Flush together with stall, then jal / jalr predecode
    ph2 = 1'b1;
    ads(32'h14); ads(32'h1C); ads(32'h20); ads(32'h24); ads(32'h28);
    ent(32'h14, JAL, 1'b1); ent(32'h1C, JALR, 1'b0); ent(32'h20, NOP, 1'b0);
    flush_quiet(32'h14);
    release_run(3);

    // Backward beq loops to 0x0C
    ads(32'h10); ads(32'h0C); ads(32'h10); ads(32'h0C); ads(32'h10);
    ent(32'h10, BEQ, 1'b1); ent(32'h0C, NOP, 1'b0); ent(32'h10, BEQ, 1'b1);
    flush_quiet(32'h10);
    release_run(3);

    // Flush in the same cycle as an ack: acked word dropped
    ads(32'h0C); ads(32'h10); ads(32'h40); ads(32'h44); ads(32'h48); ads(32'h4C);
    ent(32'h0C, NOP, 1'b0); ent(32'h10, BEQ, 1'b1); ent(32'h40, NOP, 1'b0); ent(32'h44, NOP, 1'b0);
    i_stall = 1'b0;
    tick(2);
    i_flush = 1'b1; i_branch_pc = 32'h40;
    tick(1);
    i_flush = 1'b0;
    @(negedge clk);
    chk("coll_valid", o_valid, 1'b0);
    chk("coll_addr",  o_imem_addr, 32'h40);
    @(posedge clk); #1;
    tick(2);
    i_stall = 1'b1;
    tick(2);

    // Flush with a request outstanding on 3-cycle memory
    lat = 3;
    ads(32'h50); ads(32'h100); ads(32'h104); ads(32'h108);
    ent(32'h48, NOP, 1'b0); ent(32'h4C, NOP, 1'b0); ent(32'h100, NOP, 1'b0);
    i_stall = 1'b0;
    tick(2);
    i_flush = 1'b1; i_branch_pc = 32'h100;
    tick(1);
    i_flush = 1'b0;
    @(negedge clk);
    chk("sq_req",   o_imem_req, 1'b1);
    chk("sq_addr",  o_imem_addr, 32'h50);
    chk("sq_valid", o_valid, 1'b0);
    chk("sq_state", dbg_state, ST_SQUASH);
    @(posedge clk); #1;
    tick(1);
    @(negedge clk);
    chk("redir_addr",  o_imem_addr, 32'h100);
    chk("redir_req",   o_imem_req, 1'b1);
    chk("redir_valid", o_valid, 1'b0);
    @(posedge clk); #1;
    tick(3);
    tick(1);
    i_stall = 1'b1;
    tick(8);

    // Reset mid-stream with one entry buffered and a request pending
    ent(32'h104, NOP, 1'b0);
    i_stall = 1'b0;
    tick(1);
    i_stall = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1 check_reset();
    lat = 0; i_stall = 1'b0;
    tick(2);
    ads(32'h0); ads(32'h4); ads(32'h8); ads(32'hC);
    ent(32'h0, NOP, 1'b0); ent(32'h4, NOP, 1'b0);
    reset_run(3);
    tick(3);

    chk("exp_q_left",    exp_q.size(), 0);
    chk("exp_addr_left", exp_addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++; n_bad++;
    $display("FAIL timeout: bench did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
